// File: rtl/sync_fifo_pkg.sv
// Shared buffer utilities: pointer/count width helpers and modulo-depth pointer increment.
package sync_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wrap is an explicit compare so non-power-of-two depths never rely on overflow.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Modulo-DEPTH pointer with enable; advances one slot per enabled edge.
// Latency: new value visible after the enabling edge; no backpressure of its own.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  assign ptr_d = PW'(wrap_inc(32'(ptr_q), 32'(DEPTH)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head word visible on data_out one edge after its push.
// Pushes while full are dropped unless a pop happens on the same edge; pops while empty are ignored.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            read_update,
  input  logic            write_enable,
  input  logic [SIZE-1:0] data_in,
  output logic [SIZE-1:0] data_out,
  output logic            empty,
  output logic            full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic            push;
  logic            pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push = write_enable && (!full || read_update);
  assign pop  = read_update && !empty;

  sync_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wp (
    .clk   (clk),
    .reset (reset),
    .en_i  (push),
    .ptr_o (wp)
  );

  sync_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rp (
    .clk   (clk),
    .reset (reset),
    .en_i  (pop),
    .ptr_o (rp)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wp] <= data_in;
      end
    end
  end

  assign data_out = mem_q[rp];

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo (SIZE=8, DEPTH=5) against a queue-based model.
module tb_sync_fifo;

  localparam int SIZE  = 8;
  localparam int DEPTH = 5;

  logic            clk;
  logic            reset;
  logic            read_update;
  logic            write_enable;
  logic [SIZE-1:0] data_in;
  logic [SIZE-1:0] data_out;
  logic            empty;
  logic            full;

  sync_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_update  (read_update),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              occ      = 0;
  bit              mon_en   = 1'b0;
  logic [SIZE-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one cycle of requests; model decides acceptance from occupancy alone.
  task automatic step(input bit we, input bit re, input logic [SIZE-1:0] d);
    bit push_ok;
    bit pop_ok;
    write_enable = we;
    read_update  = re;
    data_in      = d;
    push_ok = we && (occ < DEPTH || re);
    pop_ok  = re && (occ > 0);
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    occ = occ + int'(push_ok) - int'(pop_ok);
  endtask

  // Monitor: mid-cycle, check flags and head word; retire the head when the DUT pops it.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("empty_flag", 32'(empty), 32'(occ == 0));
      chk("full_flag", 32'(full), 32'(occ == DEPTH));
      if (occ > 0 && sb.size() > 0) chk("head_word", 32'(data_out), 32'(sb[0]));
      if (read_update && !empty && sb.size() > 0) void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    read_update  = 1'b0;
    write_enable = 1'b0;
    data_in      = '0;

    // Reset asserted mid-phase must take effect without a clock edge.
    #3 reset = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    chk("rst_idle_empty", 32'(empty), 32'd1);
    chk("rst_idle_dout", 32'(data_out), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("idle_empty", 32'(empty), 32'd1);

    // Single word fall-through.
    step(1, 0, 8'hA5);
    chk("single_dout", 32'(data_out), 32'hA5);
    chk("single_empty", 32'(empty), 32'd0);
    step(0, 1, 8'h00);
    chk("single_pop_empty", 32'(empty), 32'd1);

    // Fill and overflow: 0x06/0x07 dropped.
    for (int v = 1; v <= 7; v++) begin
      step(1, 0, 8'(v));
      if (v == 5) chk("fill_full", 32'(full), 32'd1);
    end
    chk("ovf_head", 32'(data_out), 32'h01);
    for (int k = 1; k <= 5; k++) begin
      chk("ovf_order", 32'(data_out), 32'(k));
      step(0, 1, 8'h00);
    end
    chk("ovf_drained", 32'(empty), 32'd1);

    // Underflow leaves pointers alone.
    for (int k = 0; k < 3; k++) step(0, 1, 8'h00);
    step(1, 0, 8'h3C);
    chk("udf_dout", 32'(data_out), 32'h3C);
    chk("udf_empty", 32'(empty), 32'd0);
    step(0, 1, 8'h00);

    // Push and pop on the same edge while empty: only the push lands.
    step(1, 1, 8'h77);
    chk("pp_empty_dout", 32'(data_out), 32'h77);
    step(0, 1, 8'h00);

    // Streaming with wrap: pops start after the FIFO fills.
    for (int i = 0; i < 45; i++) begin
      step(i < 40, i >= 5, 8'($urandom));
      if (i >= 4 && i < 39) chk("stream_full", 32'(full), 32'd1);
    end
    chk("stream_drained", 32'(empty), 32'd1);

    // Reset mid-stream with three words held.
    for (int k = 0; k < 3; k++) step(1, 0, 8'($urandom));
    reset = 1'b1;
    sb.delete();
    occ = 0;
    #1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_dout", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 0, 8'h5A);
    chk("mrst_push", 32'(data_out), 32'h5A);
    step(0, 1, 8'h00);
    chk("mrst_pop_empty", 32'(empty), 32'd1);

    // Random traffic, alternating bias to visit both full and empty regions.
    for (int i = 0; i < 400; i++) begin
      int wp_pct;
      wp_pct = ((i / 50) % 2 == 0) ? 70 : 35;
      step($urandom_range(0, 99) < wp_pct, $urandom_range(0, 99) < 50, 8'($urandom));
    end
    for (int k = 0; k < 2 * DEPTH && occ > 0; k++) step(0, 1, 8'h00);
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_sb", 32'(sb.size()), 32'd0);

    write_enable = 1'b0;
    read_update  = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO queue of DEPTH words, each SIZE bits wide.
- Used as a general-purpose elastic buffer between producer and consumer stages of the accelerator datapath.
- The head word is always visible on data_out; the consumer pops it with a one-cycle read_update pulse.
- Full/empty flags provide the back-pressure handshake.

Parameters:
- SIZE, 8, data word width in bits (>=1).
- DEPTH, 5, number of storage entries (>=2); does not need to be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- read_update  input  1  pop request; removes the head word at the clock edge.
- write_enable  input  1  push request; stores data_in at the clock edge.
- data_in  input  SIZE  word to push.
- data_out  output  SIZE  current head word (combinational read of the read-pointer location).
- empty  output  1  high when occupancy == 0.
- full  output  1  high when occupancy == DEPTH.

Behaviour:
- Storage:
  - DEPTH x SIZE register array.
  - Write pointer wp, read pointer rp, each ceil(log2(DEPTH)) bits (min 1).
  - Occupancy count cnt, ceil(log2(DEPTH+1)) bits.
- Reset (asynchronous, immediate, also mid-operation):
  - wp=0, rp=0, cnt=0, all storage entries cleared to 0.
  - Result: empty=1, full=0, data_out=0.
- Flags: empty and full are decoded combinationally from cnt; they are never both high.
- Push accepted = write_enable && (!full || read_update).
  - On acceptance: mem[wp] <= data_in; wp advances.
- Pop accepted = read_update && !empty.
  - On acceptance: rp advances.
- Pointer advance is modulo DEPTH: value DEPTH-1 wraps to 0 with an explicit compare, never by bit overflow.
- cnt update:
  - Push only: +1.
  - Pop only: -1.
  - Both or neither: unchanged.
- Push when full without a pop: dropped. Storage, pointers and flags are unchanged. No error output.
- Pop when empty: ignored. This includes simultaneous push+pop when empty: the push is accepted and the pop ignored, giving cnt=1.
- Simultaneous push+pop when full: both accepted, cnt stays DEPTH, full stays high.
- Latency:
  - A word pushed at edge N appears on data_out after edge N when the FIFO was empty.
  - empty falls after edge N.
- data_out = mem[rp] at all times. When empty it shows stale or zero contents; consumers must qualify it with !empty.
- Ordering: strict first-in first-out, with no loss of accepted words across any number of pointer wraps.
- X on data_in is stored as-is. X on control inputs is not permitted.

Decomposition:
- No shared package types are required.
- The pointer-increment-with-wrap function (next = (p == DEPTH-1) ? 0 : p+1) belongs in the shared utility package so other buffers reuse it.
- One sub-module is natural: sync_fifo_ptr, a modulo-DEPTH counter with enable and asynchronous reset, instantiated twice (wp, rp).

Test Plan (SIZE=8, DEPTH=5):
- Reset, idle: assert reset mid-clock-phase -> empty=1, full=0, data_out=0 immediately; outputs stay so with no requests.
- Single word: push 0xA5 -> next cycle empty=0, data_out=0xA5; pop -> next cycle empty=1.
- Fill and overflow: push 0x01..0x07 on consecutive cycles with no pops.
  - full=1 after the 5th edge.
  - 0x06 and 0x07 are dropped.
  - Five pops return 0x01..0x05 in order; empty=1 after the 5th pop.
- Underflow: pop on empty for 3 cycles -> pointers unchanged. A following push of 0x3C is readable as data_out=0x3C, cnt=1.
- Streaming with wrap: push 40 random words every cycle; pops start 5 cycles later, one per cycle.
  - full asserts at cycle 5, and simultaneous push+pop keeps it high.
  - The popped sequence equals the first five pushed words followed by every later accepted word, matched against a scoreboard model.
  - Pointers wrap at least 7 times.
- Reset mid-stream: with cnt=3, pulse reset -> empty=1, full=0 at once. Subsequent push/pop of 0x5A works from rp=wp=0.
